alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU in the datapath.
- Adds the following over that ALU:
  - a registered result and flag register (PSR-style C, L, F, Z, N);
  - logical and arithmetic shifts;
  - an iterative shift-add multiply;
  - a start/busy/done handshake so the control FSM can stall on multi-cycle ops.
- Sits between the register file read ports and the writeback mux; the control FSM drives start/op.

Parameters:
- DATA_WIDTH, 16, operand/result width in bits (>= 4).
- SHAMT_W, 4, width of the shift amount taken from b[SHAMT_W-1:0]; must equal clog2(DATA_WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  launch operation; sampled only when busy=0
- op  input  4  operation select (encoding below)
- a  input  DATA_WIDTH  operand A, captured at accepted start
- b  input  DATA_WIDTH  operand B, captured at accepted start
- result  output  DATA_WIDTH  registered result, held until next done
- C, L, F, Z, N  output  1 each  registered flags, updated only on done
- busy  output  1  high while a multi-cycle op is in progress
- done  output  1  one-cycle pulse, result/flags valid from this cycle

Behaviour:
- Reset (rst_n=0, async): result=0, C=L=F=Z=N=0, busy=0, done=0, FSM=IDLE, internal counters/accumulators cleared.
  - Reset mid-multiply aborts it; no done pulse is produced.
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(a)
  - 6 LSH: logical shift of a by b[SHAMT_W-1:0]; left if b[DATA_WIDTH-1]=0, right if 1
  - 7 ASHR: arithmetic shift right of a by b[SHAMT_W-1:0]
  - 8 MUL: low DATA_WIDTH bits of unsigned a*b
  - 9 CMP: flags as SUB; result register NOT updated
  - 10..15: result=0, all flags 0 except Z=1 and L per rule below
- FSM states: IDLE, MUL_RUN, DONE.
- IDLE:
  - start=1 and op!=8: compute combinationally from a,b; register result/flags at this edge; done=1 in the next cycle. Latency is 1 and busy stays 0.
  - start=1 and op=8: latch a,b; clear the accumulator; load counter=DATA_WIDTH; go to MUL_RUN; busy=1 from the next cycle.
- MUL_RUN:
  - Each cycle: if multiplier LSB=1, add multiplicand to accumulator; multiplicand <<=1, multiplier >>=1; counter -= 1.
  - When counter reaches 0, register result/flags and go to DONE.
  - Total latency: start edge to done = DATA_WIDTH+1 cycles.
- DONE: done=1, busy=0, return to IDLE; a start in this cycle is accepted as if in IDLE (back-to-back allowed).
- start while busy=1 is ignored (no queuing); a, b, op changes during MUL_RUN have no effect.
- Flags:
  - ADD: {C,sum}=a+b with DATA_WIDTH+1-bit width; F=signed overflow; N=true sign of the infinite-precision result (= sum MSB XOR F).
  - SUB/CMP: {C,diff}=a-b with DATA_WIDTH+1 bits, so C=1 means unsigned borrow (a<b unsigned); F=signed overflow; N=true sign as for ADD.
  - Logic ops and shifts: C=F=N=0.
  - MUL: C=1 if the upper DATA_WIDTH bits of the full product are nonzero; F=N=0.
  - All ops: Z = (computed result == 0), using the SUB difference for CMP; L = ($signed(a) < $signed(b)) on the captured operands.
- Shift boundaries:
  - Shift amount 0 returns a unchanged.
  - ASHR by DATA_WIDTH-1 yields all sign bits.
  - Bits of b above SHAMT_W, other than the MSB direction bit for LSH, are ignored.
- Flags and result hold their values between done pulses.

Decomposition:
- Shared package (alu_pkg) holds:
  - op-code localparams (OP_ADD..OP_CMP);
  - FSM state encodings;
  - a flags struct/bundle order {C,L,F,Z,N} for consistency with the PSR write logic.
- One sub-module, alu_mul_iter: the iterative multiplier datapath (counter, accumulator, shift regs) with a load/run/finish interface. All single-cycle ops remain in alu_seq.

Test Plan:
- ADD 0x7FFF+0x0001 -> one cycle after start: done=1, result=0x8000, F=1, N=0, C=0, Z=0, L=0.
- SUB 0x0003-0x0005 -> result=0xFFFE, C=1 (borrow), N=1, F=0, L=1. Then CMP 0x0005,0x0005 -> Z=1, result still 0xFFFE.
- MUL 0x0123*0x0045 -> busy high for 16 cycles, done exactly 17 cycles after start, result=0x4E6F, C=0. Then MUL 0x8000*0x0002 -> result=0x0000, C=1, Z=1.
- LSH a=0x00F0, b=0x0004 -> 0x0F00. LSH a=0x00F0, b=0x8004 -> 0x000F. ASHR a=0x8000, b=0x000F -> 0xFFFF, N=0, C=0.
- start pulses during MUL_RUN with op=ADD -> ignored, MUL result unaffected. start asserted in the DONE cycle -> accepted, next done one cycle later.
- rst_n low for one cycle mid-MUL (cycle 8) -> all outputs 0 immediately (async), no done pulse; a following ADD 0x0002+0x0003 -> result=0x0005.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM state encoding and
// the PSR flag bundle ordered {C,L,F,Z,N} to match the PSR write logic.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
    localparam logic [OP_W-1:0] OP_LSH  = 4'd6;
    localparam logic [OP_W-1:0] OP_ASHR = 4'd7;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd8;
    localparam logic [OP_W-1:0] OP_CMP  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic c;
        logic l;
        logic f;
        logic z;
        logic n;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control FSM (master) and the ALU (slave).
interface alu_seq_if #(
    parameter int DATA_WIDTH = 16
);
    import alu_pkg::*;

    logic                  start;
    logic [OP_W-1:0]       op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] result;
    logic                  C;
    logic                  L;
    logic                  F;
    logic                  Z;
    logic                  N;
    logic                  busy;
    logic                  done;

    modport master (
        output start, op, a, b,
        input  result, C, L, F, Z, N, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, C, L, F, Z, N, busy, done
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, full
// 2*DATA_WIDTH product so the top can flag overflow of the low half.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SHAMT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    run,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    finish,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = SHAMT_W + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH);

    logic [PW-1:0]         mcand_q, mcand_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [PW-1:0]         acc_step;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{DATA_WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CNT_INIT;
        end else if (run && (cnt_q != '0)) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // The step that takes the counter to zero is the last one; expose its sum
    // directly so the top can register the product on that same edge.
    assign finish  = run && (cnt_q == CNT_W'(1));
    assign product = acc_step;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with PSR-style flags: single-cycle ops finish in one cycle,
// MUL runs through the iterative multiplier with a busy/done handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SHAMT_W    = 4
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);

    localparam int MSB = DATA_WIDTH - 1;
    localparam int PW  = 2 * DATA_WIDTH;

    alu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    alu_flags_t            flags_q, flags_d;
    logic                  lt_q, lt_d;

    logic                  mul_load;
    logic                  mul_run;
    logic                  mul_finish;
    logic [PW-1:0]         mul_product;

    logic [DATA_WIDTH:0]          sum_w;
    logic [DATA_WIDTH:0]          diff_w;
    logic signed [DATA_WIDTH-1:0] a_s;
    logic [SHAMT_W-1:0]           shamt;
    logic                         add_ovf;
    logic                         sub_ovf;
    logic                         lt_now;
    logic [DATA_WIDTH-1:0]        sc_res;
    alu_flags_t                   sc_flags;

    alu_mul_iter #(
        .DATA_WIDTH(DATA_WIDTH),
        .SHAMT_W   (SHAMT_W)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mul_load),
        .run    (mul_run),
        .a      (bus.a),
        .b      (bus.b),
        .finish (mul_finish),
        .product(mul_product)
    );

    always_comb begin
        sum_w   = {1'b0, bus.a} + {1'b0, bus.b};
        diff_w  = {1'b0, bus.a} - {1'b0, bus.b};
        a_s     = bus.a;
        shamt   = bus.b[SHAMT_W-1:0];
        add_ovf = (bus.a[MSB] == bus.b[MSB]) && (sum_w[MSB] != bus.a[MSB]);
        sub_ovf = (bus.a[MSB] != bus.b[MSB]) && (diff_w[MSB] != bus.a[MSB]);
        lt_now  = $signed(bus.a) < $signed(bus.b);

        sc_res     = '0;
        sc_flags   = '0;
        sc_flags.l = lt_now;
        // N is the true sign of the unbounded result, so it flips on overflow.
        case (bus.op)
            OP_ADD: begin
                sc_res     = sum_w[MSB:0];
                sc_flags.c = sum_w[DATA_WIDTH];
                sc_flags.f = add_ovf;
                sc_flags.n = sum_w[MSB] ^ add_ovf;
            end
            OP_SUB, OP_CMP: begin
                sc_res     = diff_w[MSB:0];
                sc_flags.c = diff_w[DATA_WIDTH];
                sc_flags.f = sub_ovf;
                sc_flags.n = diff_w[MSB] ^ sub_ovf;
            end
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_NOT:  sc_res = ~bus.a;
            OP_LSH:  sc_res = bus.b[MSB] ? (bus.a >> shamt) : (bus.a << shamt);
            OP_ASHR: sc_res = a_s >>> shamt;
            default: sc_res = '0;
        endcase
        sc_flags.z = (sc_res == '0);
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        lt_d     = lt_q;
        mul_load = 1'b0;
        mul_run  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
                        mul_load = 1'b1;
                        lt_d     = lt_now;
                        state_d  = ST_MUL_RUN;
                    end else begin
                        if (bus.op != OP_CMP) begin
                            result_d = sc_res;
                        end
                        flags_d = sc_flags;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_MUL_RUN: begin
                mul_run = 1'b1;
                if (mul_finish) begin
                    result_d  = mul_product[MSB:0];
                    flags_d   = '0;
                    flags_d.c = |mul_product[PW-1:DATA_WIDTH];
                    flags_d.l = lt_q;
                    flags_d.z = (mul_product[MSB:0] == '0);
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            lt_q     <= lt_d;
        end
    end

    assign bus.result = result_q;
    assign bus.C      = flags_q.c;
    assign bus.L      = flags_q.l;
    assign bus.F      = flags_q.f;
    assign bus.Z      = flags_q.z;
    assign bus.N      = flags_q.n;
    assign bus.busy   = (state_q == ST_MUL_RUN);
    assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] m_res;
    logic [4:0]  m_flags;

    alu_seq_if #(.DATA_WIDTH(DW)) bus ();

    alu_seq #(.DATA_WIDTH(DW), .SHAMT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4:0] dut_flags();
        return {bus.C, bus.L, bus.F, bus.Z, bus.N};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected result/flags from plain integer arithmetic on the operand values.
    task automatic model_apply(input logic [3:0] op_i, input logic [15:0] a_i, input logic [15:0] b_i);
        int          sa, sb, t, sh;
        longint      u;
        logic [15:0] r;
        logic        c, f, n, z, l;
        sa = int'($signed(a_i));
        sb = int'($signed(b_i));
        sh = int'(b_i[3:0]);
        r = '0; c = 1'b0; f = 1'b0; n = 1'b0;
        case (op_i)
            4'd0: begin
                u = longint'(a_i) + longint'(b_i);
                r = u[15:0];
                c = (u > 65535);
                t = sa + sb;
                n = (t < 0);
                f = (t > 32767) || (t < -32768);
            end
            4'd1, 4'd9: begin
                t = sa - sb;
                r = t[15:0];
                c = (a_i < b_i);
                n = (t < 0);
                f = (t > 32767) || (t < -32768);
            end
            4'd2: r = a_i & b_i;
            4'd3: r = a_i | b_i;
            4'd4: r = a_i ^ b_i;
            4'd5: r = ~a_i;
            4'd6: begin
                if (b_i[15]) u = longint'(a_i) / (longint'(1) << sh);
                else         u = longint'(a_i) * (longint'(1) << sh);
                r = u[15:0];
            end
            4'd7: begin
                t = sa >>> sh;
                r = t[15:0];
            end
            4'd8: begin
                u = longint'(a_i) * longint'(b_i);
                r = u[15:0];
                c = (u >= 65536);
            end
            default: r = '0;
        endcase
        z = (r == 16'h0000);
        l = (sa < sb);
        if (op_i != 4'd9) m_res = r;
        m_flags = {c, l, f, z, n};
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, " idle_done"}, 32'(bus.done), 32'd0);
        chk({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " hold_res"}, 32'(bus.result), 32'(m_res));
        chk({tag, " hold_flags"}, 32'(dut_flags()), 32'(m_flags));
    endtask

    task automatic do_single(input logic [3:0] op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                             input bit in_done_cycle, input string tag);
        if (!in_done_cycle) begin
            @(negedge clk);
            idle_checks(tag);
        end
        bus.start = 1'b1; bus.op = op_i; bus.a = a_i; bus.b = b_i;
        model_apply(op_i, a_i, b_i);
        @(negedge clk);
        bus.start = 1'b0; bus.op = 4'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " res"}, 32'(bus.result), 32'(m_res));
        chk({tag, " flags"}, 32'(dut_flags()), 32'(m_flags));
    endtask

    task automatic do_mul(input logic [15:0] a_i, input logic [15:0] b_i, input bit noise, input string tag);
        int cyc, busy_cyc;
        @(negedge clk);
        idle_checks(tag);
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = a_i; bus.b = b_i;
        model_apply(OP_MUL, a_i, b_i);
        cyc = 0; busy_cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (bus.busy) busy_cyc++;
            if (!bus.done && noise) begin
                bus.start = 1'($urandom);
                bus.op    = OP_ADD;
                bus.a     = 16'($urandom);
                bus.b     = 16'($urandom);
            end
        end while (!bus.done && cyc < 40);
        bus.start = 1'b0;
        chk({tag, " latency"}, 32'(cyc), 32'd17);
        chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'd16);
        chk({tag, " done"}, 32'(bus.done), 32'd1);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " res"}, 32'(bus.result), 32'(m_res));
        chk({tag, " flags"}, 32'(dut_flags()), 32'(m_flags));
    endtask

    initial begin
        bit          seen;
        logic [3:0]  rop;
        logic [15:0] ra, rb;

        m_res = '0; m_flags = '0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("reset res", 32'(bus.result), 32'd0);
        chk("reset flags", 32'(dut_flags()), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;

        do_single(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
        chk("add_ovf const_res", 32'(bus.result), 32'h8000);
        chk("add_ovf const_flags", 32'(dut_flags()), 32'b00100);

        do_single(OP_SUB, 16'h0003, 16'h0005, 1'b0, "sub_borrow");
        chk("sub const_res", 32'(bus.result), 32'hFFFE);
        chk("sub const_flags", 32'(dut_flags()), 32'b11001);

        do_single(OP_CMP, 16'h0005, 16'h0005, 1'b0, "cmp_eq");
        chk("cmp const_res", 32'(bus.result), 32'hFFFE);
        chk("cmp const_flags", 32'(dut_flags()), 32'b00010);

        do_mul(16'h0123, 16'h0045, 1'b1, "mul_noise");
        chk("mul const_res", 32'(bus.result), 32'h4E6F);
        chk("mul const_flags", 32'(dut_flags()), 32'b00000);

        do_mul(16'h8000, 16'h0002, 1'b0, "mul_carry");
        chk("mul_carry const_res", 32'(bus.result), 32'h0000);
        chk("mul_carry const_flags", 32'(dut_flags()), 32'b11010);
        do_single(OP_ADD, 16'h1111, 16'h2222, 1'b1, "b2b_add");
        chk("b2b const_res", 32'(bus.result), 32'h3333);

        do_single(OP_LSH, 16'h00F0, 16'h0004, 1'b0, "lsh_left");
        chk("lsh_left const", 32'(bus.result), 32'h0F00);
        do_single(OP_LSH, 16'h00F0, 16'h8004, 1'b0, "lsh_right");
        chk("lsh_right const", 32'(bus.result), 32'h000F);
        do_single(OP_ASHR, 16'h8000, 16'h000F, 1'b0, "ashr_max");
        chk("ashr_max const_res", 32'(bus.result), 32'hFFFF);
        chk("ashr_max const_cn", 32'({bus.C, bus.N}), 32'd0);
        do_single(OP_LSH, 16'hA5C3, 16'h7FF0, 1'b0, "lsh_zero");
        chk("lsh_zero const", 32'(bus.result), 32'hA5C3);
        do_single(OP_ASHR, 16'h9234, 16'h0000, 1'b0, "ashr_zero");
        do_single(4'd12, 16'h1234, 16'h0001, 1'b0, "reserved");
        chk("reserved const_flags", 32'(dut_flags()), 32'b00010);

        do_single(OP_SUB, 16'h0003, 16'h0005, 1'b0, "sub_pre_rst");
        @(negedge clk);
        idle_checks("pre_rst");
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = 16'h1234; bus.b = 16'h5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("rst busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async_res", 32'(bus.result), 32'd0);
        chk("rst async_flags", 32'(dut_flags()), 32'd0);
        chk("rst async_busy", 32'(bus.busy), 32'd0);
        chk("rst async_done", 32'(bus.done), 32'd0);
        m_res = '0; m_flags = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("rst no_done", 32'(seen), 32'd0);
        do_single(OP_ADD, 16'h0002, 16'h0003, 1'b0, "add_post_rst");
        chk("add_post_rst const", 32'(bus.result), 32'h0005);

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
            if (rop == OP_MUL) do_mul(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_mul", i));
            else               do_single(rop, ra, rb, 1'b0, $sformatf("rnd%0d_op%0d", i, rop));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
